f3m_scalar_recover: RTL and testbench
=====================================

# f3m_scalar_recover

Sequential recovery of the GF(3) scalar `aa` from a GF(3^M) element `A` and its coefficient-wise product `C = aa·A`. It is the decode counterpart of the scalar-multiply stage in the ECC/pairing datapath. The block scans digit pairs of `A` and `C`, derives `aa` from the lowest nonzero digit of `A`, and optionally verifies the product across every digit. Typical users are the pairing controller's self-check path and point-compression verification.

## Interface
Parameters:
- `M`, 97: field extension degree; elements are `2*M+2` bits wide (98 digits of 2 bits each).
- `D`, 2: digits processed per scan beat; must divide `M+1`.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  reset, asynchronous, active-low.
- `start`  input  1  request; accepted only when `busy`=0.
- `A`  input  2*M+2  operand element; sampled on the accepting edge.
- `C`  input  2*M+2  product element; sampled on the accepting edge.
- `busy`  output  1  scan in progress.
- `done`  output  1  one-cycle pulse when the result registers update.
- `aa`  output  2  recovered scalar (00=0, 01=1, 10=2).
- `ok`  output  1  `C` is consistent with `aa·A`.
- `zero`  output  1  `A` is the all-zero element.

## Operation
- Digit encoding: 00=0, 01=1, 10=2. Code 11 is illegal.
- States:
  - IDLE: on `start`, latch `A` and `C` into shift registers, clear the scratch flags, go to SCAN.
  - SCAN: consume the lowest `D` digits per beat, digit 0 first, then shift right by `2*D`.
  - DONE: register the results, pulse `done`, return to IDLE.
- Scalar rule: the lowest digit index i with `A_i`≠0 gives `aa = C_i · A_i` in GF(3), because every nonzero GF(3) element is its own inverse. Within a beat, the lowest index has priority. Once found, `aa` is frozen.
- If `A` has no nonzero digit: `zero`=1 and `aa`=00. `ok`=1 iff every digit of `C` is 0.
- Any illegal 11 digit in `A` or `C` forces `ok`=0.
- Arithmetic is GF(3) digit multiplication only. No carries. No reduction by the irreducible polynomial.
- `start` while `busy`=1 is ignored. It is not queued.
- `aa`, `ok` and `zero` hold their values until the next `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `aa`=00, `ok`=0, `zero`=0, state IDLE, shift registers cleared.
- Reset asserted mid-scan aborts the operation immediately. No `done` is produced.
- Start is accepted at edge 0, and `busy`=1 from that edge.
- Beats occur at edges 1..(M+1)/D. The full scan is 49 beats with defaults.
- The DONE transition happens on the last beat's edge. On that edge, `done`=1, `busy`=0 and the results are valid, all together.
- `done` lasts exactly one cycle.
- A new `start` is accepted in the same cycle `done` is high, because `busy`=0.
- Back-to-back throughput is one operation per (M+1)/D+1 cycles.

## Configuration
- `F3M_RECOVER_CHECK_EN` defined:
  - Full consistency check. Every digit j must satisfy `C_j == aa·A_j`.
  - Digits below the first nonzero `A` digit must have `C_j`=0.
  - Scan length is always (M+1)/D beats.
- `F3M_RECOVER_CHECK_EN` undefined:
  - Early exit. DONE is entered on the beat containing the first nonzero `A` digit.
  - `ok`=1 unless an illegal digit was seen in the digits scanned so far.
  - All-zero `A` still scans the full length; `zero`=1, `ok`=1.

## Test plan
- All `A` digits 01, all `C` digits 10, `start`: `done` on edge 49, `aa`=10, `ok`=1, `zero`=0. Without the macro, `done` on edge 1.
- `A`=0 and `C`=0: `aa`=00, `zero`=1, `ok`=1. Then `A`=0 with `C` digit 40 = 01: `zero`=1, and `ok`=0 with the macro.
- `A` digit 0=01 and digit 5=10; `C` digit 0=10 and digit 5=10: `aa`=10. With the macro `ok`=0, because 2·2=1 is expected at digit 5. Without the macro `ok`=1.
- `A` digit 3=10 (lower digits 0), `C` digit 3=10: `aa`=01. Same case with `C` digit 1=11 (illegal): `ok`=0.
- `start` pulsed on edges 5 and 20 during a scan: ignored; exactly one `done`, at edge 49.
- `reset` low at edge 10 mid-scan: all outputs 0 at once and no `done`. After reset, `start` with case 1 completes normally.

Source files
------------

// File: rtl/f3m_scalar_recover_if.sv
// f3m_scalar_recover_if: request/result bundle for the GF(3) scalar recovery block.
//   start        request strobe, honoured only while busy=0
//   A, C         operand element and its product element, 2 bits per digit, digit 0 at LSBs
//   busy         scan in progress
//   done         one-cycle pulse when aa/ok/zero update
//   aa, ok, zero recovered scalar, consistency flag, all-zero-A flag
// Modports: master drives the request side, slave is the recovery block.
interface f3m_scalar_recover_if #(
  parameter int unsigned M = 97
);
  logic             start;
  logic [2*M+1:0]   A;
  logic [2*M+1:0]   C;
  logic             busy;
  logic             done;
  logic [1:0]       aa;
  logic             ok;
  logic             zero;

  modport master (
    output start, A, C,
    input  busy, done, aa, ok, zero
  );

  modport slave (
    input  start, A, C,
    output busy, done, aa, ok, zero
  );
endinterface

// File: rtl/f3m_scalar_recover.sv
// f3m_scalar_recover: recovers the GF(3) scalar aa from an element A and C = aa*A by scanning
// D digit pairs per beat, lowest digit first. aa comes from the lowest nonzero digit of A
// (aa = C_i * A_i, since every nonzero GF(3) element is its own inverse).
//
// Build option: define F3M_RECOVER_CHECK_EN to check every digit (C_j == aa*A_j, and C_j == 0
// below the first nonzero A digit) over the full scan. Without it the scan exits on the beat
// holding the first nonzero A digit and ok only reflects illegal (11) digits scanned so far.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; aborts a scan without a done pulse
//   bus    slave side of f3m_scalar_recover_if (start/A/C in, busy/done/aa/ok/zero out)
module f3m_scalar_recover #(
  parameter int unsigned M = 97,
  parameter int unsigned D = 2
) (
  input logic                   clk,
  input logic                   reset,
  f3m_scalar_recover_if.slave   bus
);

  localparam int unsigned N     = M + 1;
  localparam int unsigned W     = 2 * M + 2;
  localparam int unsigned Beats = N / D;
  localparam int unsigned CntW  = $clog2(Beats + 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_sh_q, a_sh_d;
  logic [W-1:0]      c_sh_q, c_sh_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Scratch flags carried across beats.
  logic              found_q, found_d;
  logic [1:0]        aa_s_q, aa_s_d;
  logic              bad_q, bad_d;
  // Result registers, held until the next done.
  logic [1:0]        aa_q, aa_d;
  logic              ok_q, ok_d;
  logic              zero_q, zero_d;

  // Beat evaluation results.
  logic              found_v;
  logic [1:0]        aa_v;
  logic              bad_v;
  logic              last_beat;

  function automatic logic [1:0] gf3_mul(input logic [1:0] x, input logic [1:0] y);
    logic [1:0] r;
    r = 2'b00;
    unique case ({x, y})
      4'b0101: r = 2'b01;
      4'b0110: r = 2'b10;
      4'b1001: r = 2'b10;
      4'b1010: r = 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Walk the D low digits in index order so the lowest nonzero A digit wins within a beat.
  always_comb begin
    logic [1:0] a_dig;
    logic [1:0] c_dig;
    logic [1:0] exp_c;
    found_v = found_q;
    aa_v    = aa_s_q;
    bad_v   = bad_q;
    a_dig   = 2'b00;
    c_dig   = 2'b00;
    exp_c   = 2'b00;
    for (int i = 0; i < int'(D); i++) begin
      a_dig = a_sh_q[2*i +: 2];
      c_dig = c_sh_q[2*i +: 2];
      if (a_dig == 2'b11 || c_dig == 2'b11) begin
        bad_v = 1'b1;
      end else begin
        if (!found_v && a_dig != 2'b00) begin
          found_v = 1'b1;
          aa_v    = gf3_mul(c_dig, a_dig);
        end
`ifdef F3M_RECOVER_CHECK_EN
        // Before the first nonzero A digit the expected product is 0.
        exp_c = found_v ? gf3_mul(aa_v, a_dig) : 2'b00;
        if (c_dig != exp_c) begin
          bad_v = 1'b1;
        end
`endif
      end
    end
  end

  always_comb begin
    last_beat = (cnt_q == CntW'(Beats - 1));
`ifndef F3M_RECOVER_CHECK_EN
    last_beat = last_beat | found_v;
`endif
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    c_sh_d  = c_sh_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    aa_s_d  = aa_s_q;
    bad_d   = bad_q;
    aa_d    = aa_q;
    ok_d    = ok_q;
    zero_d  = zero_q;
    unique case (state_q)
      // StDone accepts a new start just like StIdle, giving back-to-back operation.
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          state_d = StScan;
          a_sh_d  = bus.A;
          c_sh_d  = bus.C;
          cnt_d   = '0;
          found_d = 1'b0;
          aa_s_d  = 2'b00;
          bad_d   = 1'b0;
        end
      end
      StScan: begin
        a_sh_d  = a_sh_q >> (2 * D);
        c_sh_d  = c_sh_q >> (2 * D);
        cnt_d   = cnt_q + CntW'(1);
        found_d = found_v;
        aa_s_d  = aa_v;
        bad_d   = bad_v;
        if (last_beat) begin
          state_d = StDone;
          aa_d    = found_v ? aa_v : 2'b00;
          ok_d    = ~bad_v;
          zero_d  = ~found_v;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      c_sh_q  <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      aa_s_q  <= 2'b00;
      bad_q   <= 1'b0;
      aa_q    <= 2'b00;
      ok_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      c_sh_q  <= c_sh_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      aa_s_q  <= aa_s_d;
      bad_q   <= bad_d;
      aa_q    <= aa_d;
      ok_q    <= ok_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy = (state_q == StScan);
  assign bus.done = (state_q == StDone);
  assign bus.aa   = aa_q;
  assign bus.ok   = ok_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_f3m_scalar_recover.sv
module tb_f3m_scalar_recover;

  localparam int M     = 97;
  localparam int D     = 2;
  localparam int N     = M + 1;
  localparam int W     = 2 * M + 2;
  localparam int BEATS = N / D;

  typedef struct {
    logic [1:0] aa;
    logic       ok;
    logic       zero;
    longint     cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  exp_t   sb[$];
  int     ad[N];
  int     cd[N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  f3m_scalar_recover_if #(.M(M)) bus ();

  f3m_scalar_recover #(.M(M), .D(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input int d[N]);
    logic [W-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[2*j +: 2] = 2'(d[j]);
    return v;
  endfunction

  // Reference: digits as integers, GF(3) product as (x*y) mod 3, 3 stands for the illegal code.
  function automatic exp_t model(input longint now);
    exp_t e;
    int   f;
    int   lat;
    int   upto;
    int   exp_c;
    f = -1;
    for (int j = 0; j < N; j++) if (f < 0 && ad[j] != 0) f = j;
    e.zero = (f < 0);
    e.aa   = (f < 0) ? 2'd0 : 2'((cd[f] * ad[f]) % 3);
    e.ok   = 1'b1;
`ifdef F3M_RECOVER_CHECK_EN
    lat = BEATS;
    for (int j = 0; j < N; j++) begin
      exp_c = (f < 0 || j < f) ? 0 : (int'(e.aa) * ad[j]) % 3;
      if (ad[j] == 3 || cd[j] == 3 || cd[j] != exp_c) e.ok = 1'b0;
    end
`else
    if (f < 0) begin
      lat  = BEATS;
      upto = N;
    end else begin
      lat  = f / D + 1;
      upto = lat * D;
    end
    for (int j = 0; j < upto; j++) if (ad[j] == 3 || cd[j] == 3) e.ok = 1'b0;
`endif
    e.cyc = now + 1 + lat;
    return e;
  endfunction

  // Monitor: every done pops one expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no done (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("aa", longint'(bus.aa), longint'(e.aa));
        check("ok", longint'(bus.ok), longint'(e.ok));
        check("zero", longint'(bus.zero), longint'(e.zero));
        check("done_cycle", cyc, e.cyc);
        check("busy_at_done", longint'(bus.busy), 0);
      end
    end
  end

  task automatic clear_digits();
    for (int j = 0; j < N; j++) begin
      ad[j] = 0;
      cd[j] = 0;
    end
  endtask

  // Called at a negedge; drives start for one edge once busy is low.
  task automatic issue();
    int guard;
    guard = 0;
    while (bus.busy && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      check("issue_timeout", 1, 0);
    end else begin
      bus.start = 1'b1;
      bus.A     = pack(ad);
      bus.C     = pack(cd);
      sb.push_back(model(cyc));
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic rand_digits();
    int f;
    int s;
    int r;
    int j;
    clear_digits();
    f = ($urandom_range(0, 9) == 0) ? -1
      : ($urandom_range(0, 1) == 0 ? $urandom_range(0, 9) : $urandom_range(0, N - 1));
    s = $urandom_range(0, 2);
    for (int k = 0; k < N; k++) begin
      if (f < 0 || k < f) ad[k] = 0;
      else if (k == f)    ad[k] = $urandom_range(1, 2);
      else                ad[k] = $urandom_range(0, 2);
      cd[k] = (s * ad[k]) % 3;
    end
    r = $urandom_range(0, 3);
    if (r == 1) begin
      cd[$urandom_range(0, N - 1)] = $urandom_range(0, 2);
    end else if (r == 2) begin
      for (int t = 0; t < 8; t++) begin
        j = $urandom_range(0, N - 1);
        if (ad[j] == 0) begin
          cd[j] = 3;
          break;
        end
      end
    end
  endtask

  task automatic case_all_ones();
    clear_digits();
    for (int j = 0; j < N; j++) begin
      ad[j] = 1;
      cd[j] = 2;
    end
  endtask

  task automatic case_top_digit();
    clear_digits();
    ad[N-1] = 1;
    cd[N-1] = 2;
  endtask

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.C     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", longint'(bus.busy), 0);
    check("reset_done", longint'(bus.done), 0);
    check("reset_aa", longint'(bus.aa), 0);
    check("reset_ok", longint'(bus.ok), 0);
    check("reset_zero", longint'(bus.zero), 0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases.
    case_all_ones();
    issue();
    wait_idle();
    clear_digits();
    issue();
    wait_idle();
    clear_digits();
    cd[40] = 1;
    issue();
    wait_idle();
    clear_digits();
    ad[0] = 1; ad[5] = 2; cd[0] = 2; cd[5] = 2;
    issue();
    wait_idle();
    clear_digits();
    ad[3] = 2; cd[3] = 2;
    issue();
    wait_idle();
    cd[1] = 3;
    issue();
    wait_idle();

    // Starts at edges 5 and 20 of a full-length scan must be ignored.
    case_top_digit();
    issue();
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = '1;
    bus.C     = '1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    check("idle_after_ignored", longint'(bus.busy), 0);

    // Reset mid-scan at edge 10: outputs clear at once, no done afterwards.
    case_top_digit();
    issue();
    repeat (9) @(negedge clk);
    sb.delete();
    reset = 1'b0;
    #1;
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_done", longint'(bus.done), 0);
    check("abort_aa", longint'(bus.aa), 0);
    check("abort_ok", longint'(bus.ok), 0);
    check("abort_zero", longint'(bus.zero), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    case_all_ones();
    issue();
    wait_idle();

    // Randomized back-to-back traffic.
    for (int n = 0; n < 40; n++) begin
      rand_digits();
      issue();
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
